// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB LED arbiter: colour struct, arbiter
// state encoding and the round-robin next-pending search.
package rgb_pkg;

    // Default channel width for the colour struct below.
    localparam int RGB_PWM_BITS = 8;

    // Widest requester vector the round-robin search can handle.
    localparam int RR_MAX_REQ = 8;

    // One 24-bit colour, red in the MSBs.
    typedef struct packed {
        logic [RGB_PWM_BITS-1:0] r;
        logic [RGB_PWM_BITS-1:0] g;
        logic [RGB_PWM_BITS-1:0] b;
    } rgb_t;

    // Arbiter states: no owner, or one requester holds the LED.
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Returns the index of the first set bit of 'pending' at or after 'start',
    // wrapping at n_req. Returns 0 when nothing is pending, so callers test
    // |pending separately. 'start' must be below n_req.
    function automatic int rr_next_pending(
        input logic [RR_MAX_REQ-1:0] pending,
        input int                    start,
        input int                    n_req
    );
        int pick;
        int pos;
        bit found;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            pos = start + i;
            if (pos >= n_req) begin
                pos = pos - n_req;
            end
            if (!found && (i < n_req) &&
                (((pending >> pos) & RR_MAX_REQ'(1)) != '0)) begin
                pick  = pos;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel PWM generator. A free-running counter is compared against a
// per-channel duty that is only reloaded at the start of each period, so a
// duty change never produces a truncated or stretched pulse.
module rgb_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty_r,
    input  logic [PWM_BITS-1:0] duty_g,
    input  logic [PWM_BITS-1:0] duty_b,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b
);

    localparam int N_CH = 3;

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] cnt_d;
    logic [PWM_BITS-1:0] duty_in [N_CH];
    logic [PWM_BITS-1:0] duty_q  [N_CH];
    logic [PWM_BITS-1:0] duty_d  [N_CH];
    logic [N_CH-1:0]     led_q;
    logic [N_CH-1:0]     led_d;
    logic                period_start;

    // Channel 0 is red, 1 green, 2 blue.
    assign duty_in[0] = duty_r;
    assign duty_in[1] = duty_g;
    assign duty_in[2] = duty_b;

    assign period_start = (cnt_q == '0);

    // Counter wraps naturally; duty taken fresh at count 0 so the compare for
    // the first slot of a period already uses the new value.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        for (int ch = 0; ch < N_CH; ch++) begin
            duty_d[ch] = period_start ? duty_in[ch] : duty_q[ch];
            led_d[ch]  = (cnt_q < duty_d[ch]);
        end
    end

    // Counter, duty latches and registered LED outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            led_q <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                duty_q[ch] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                duty_q[ch] <= duty_d[ch];
            end
        end
    end

    assign led_r = led_q[0];
    assign led_g = led_q[1];
    assign led_b = led_q[2];

endmodule

// File: rtl/rgb_led_arbiter.sv
// Shares one RGB LED among N_REQ requesters. A round-robin arbiter with a
// minimum hold time picks the owner; the owner's colour feeds the PWM block.
module rgb_led_arbiter
    import rgb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int PWM_BITS    = 8,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*3*PWM_BITS-1:0] color,
    output logic [N_REQ-1:0]            gnt,
    output logic [$clog2(N_REQ)-1:0]    gnt_id,
    output logic                        busy,
    output logic                        led_r,
    output logic                        led_g,
    output logic                        led_b
);

    localparam int IDW    = $clog2(N_REQ);
    localparam int CW     = 3 * PWM_BITS;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    // Saturation value of the hold counter, and the value from which the
    // next increment saturates. The owner may be preempted on the edge where
    // the counter would saturate, so it keeps the LED HOLD_CYCLES cycles.
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } color_t;

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [IDW-1:0]        owner_q;
    logic [IDW-1:0]        owner_d;
    logic [IDW-1:0]        ptr_q;
    logic [IDW-1:0]        ptr_d;
    logic [HOLD_W-1:0]     hold_q;
    logic [HOLD_W-1:0]     hold_d;
    logic [RR_MAX_REQ-1:0] pend_all;
    logic [RR_MAX_REQ-1:0] pend_others;
    logic [N_REQ-1:0]      owner_mask;
    logic                  owner_req;
    logic                  busy_w;
    logic [CW-1:0]         color_slice [N_REQ];
    color_t                owner_color;

    assign busy_w = (state_q == OWNED);

    // Decode the owner to a one-hot mask and split the colour bus per requester.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign owner_mask[gi]  = (owner_q == IDW'(gi));
            assign color_slice[gi] = color[gi*CW +: CW];
        end
    endgenerate

    assign owner_req = |(req & owner_mask);

    // Pad request vectors to the search helper's width; the owner is masked
    // out of pend_others so a release-and-rerequest never re-grants directly.
    always_comb begin
        pend_all                 = '0;
        pend_others              = '0;
        pend_all[N_REQ-1:0]      = req;
        pend_others[N_REQ-1:0]   = req & ~owner_mask;
    end

    // Index following 'idx', wrapping at N_REQ.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
        if (int'(idx) == N_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Next-state logic. While OWNED the pointer always equals owner+1, so
    // searching pend_others from the pointer finds the next pending requester
    // after the owner.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (|pend_all) begin
                    state_d = OWNED;
                    owner_d = IDW'(rr_next_pending(pend_all, int'(ptr_q), N_REQ));
                    ptr_d   = wrap_inc(owner_d);
                end
            end
            OWNED: begin
                if (!owner_req && !(|pend_others)) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if ((!owner_req || (hold_q >= HOLD_LAST)) && (|pend_others)) begin
                    owner_d = IDW'(rr_next_pending(pend_others, int'(ptr_q), N_REQ));
                    ptr_d   = wrap_inc(owner_d);
                    hold_d  = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt    = busy_w ? owner_mask : '0;
    assign gnt_id = owner_q;
    assign busy   = busy_w;

    // Only the owner's colour reaches the PWM; dark when nobody owns the LED.
    assign owner_color = busy_w ? color_t'(color_slice[owner_q]) : '0;

    rgb_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty_r (owner_color.r),
        .duty_g (owner_color.g),
        .duty_b (owner_color.b),
        .led_r  (led_r),
        .led_g  (led_g),
        .led_b  (led_b)
    );

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Self-checking bench for rgb_led_arbiter with directed scenarios and a
// randomized run against a rule-level reference model.
module tb_rgb_led_arbiter;

    localparam int N_REQ    = 4;
    localparam int PWM_BITS = 4;
    localparam int HOLD     = 8;
    localparam int PERIOD   = 1 << PWM_BITS;
    localparam int CW       = 3 * PWM_BITS;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_REQ-1:0]      req;
    logic [N_REQ*CW-1:0]   color;
    logic [N_REQ-1:0]      gnt;
    logic [1:0]            gnt_id;
    logic                  busy;
    logic                  led_r;
    logic                  led_g;
    logic                  led_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: owner, cycles held so far, next search start,
    // position within the PWM period and the duty frozen for that period.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_held;
    int m_cnt;
    int m_duty [3];
    bit m_led  [3];

    always #5 clk = ~clk;

    rgb_led_arbiter #(
        .N_REQ       (N_REQ),
        .PWM_BITS    (PWM_BITS),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .color  (color),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .led_r  (led_r),
        .led_g  (led_g),
        .led_b  (led_b)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int next_pending(input logic [N_REQ-1:0] r, input int from);
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = (from + i) % N_REQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic int chan_of(input int who, input int ch);
        logic [CW-1:0] slot;
        slot = color[who*CW +: CW];
        return int'(slot[(2-ch)*PWM_BITS +: PWM_BITS]);
    endfunction

    function automatic logic [N_REQ-1:0] exp_gnt();
        logic [N_REQ-1:0] g;
        g = '0;
        if (m_busy) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [2:0] exp_led();
        return {m_led[0], m_led[1], m_led[2]};
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_cnt   = 0;
        for (int ch = 0; ch < 3; ch++) begin
            m_duty[ch] = 0;
            m_led[ch]  = 1'b0;
        end
    endtask

    task automatic model_grant(input int w);
        m_busy  = 1'b1;
        m_owner = w;
        m_ptr   = (w + 1) % N_REQ;
        m_held  = 1;
    endtask

    // Advances the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        logic [N_REQ-1:0] others;
        int w;
        if (m_cnt == 0) begin
            for (int ch = 0; ch < 3; ch++) m_duty[ch] = m_busy ? chan_of(m_owner, ch) : 0;
        end
        for (int ch = 0; ch < 3; ch++) m_led[ch] = (m_cnt < m_duty[ch]);
        m_cnt = (m_cnt + 1) % PERIOD;
        if (!m_busy) begin
            w = next_pending(req, m_ptr);
            if (w >= 0) model_grant(w);
        end else begin
            others = req;
            others[m_owner] = 1'b0;
            w = next_pending(others, (m_owner + 1) % N_REQ);
            if (!req[m_owner]) begin
                if (w >= 0) model_grant(w);
                else m_busy = 1'b0;
            end else if (m_held >= HOLD && w >= 0) begin
                model_grant(w);
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({gnt, gnt_id, busy, led_r, led_g, led_b} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b id=%0d busy=%b leds=%b%b%b expected all 0",
                     gnt, gnt_id, busy, led_r, led_g, led_b);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: cycle %0d got gnt=%b busy=%b expected 0000/0", k, gnt, busy);
            end
        end
    endtask

    task automatic test_single();
        int cr;
        int cg;
        int cb;
        apply_reset();
        color = {$urandom(), $urandom()};
        color[2*CW +: CW] = 12'hF80;
        req = 4'b0100;
        step();
        n_checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b id=%0d busy=%b expected 0100/2/1", gnt, gnt_id, busy);
        end
        for (int k = 0; k < PERIOD && m_cnt != 0; k++) step();
        cr = 0; cg = 0; cb = 0;
        for (int k = 0; k < PERIOD; k++) begin
            step();
            cr += int'(led_r);
            cg += int'(led_g);
            cb += int'(led_b);
        end
        n_checks++;
        if (cr != 15 || cg != 8 || cb != 0) begin
            n_fail++;
            $display("FAIL single_duty: got r=%0d g=%0d b=%0d expected 15/8/0", cr, cg, cb);
        end
    endtask

    task automatic test_reset_mid();
        step();
        step();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got busy=%b expected 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, gnt_id, busy, led_r, led_g, led_b} !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset_async: got gnt=%b id=%0d busy=%b leds=%b%b%b expected all 0",
                     gnt, gnt_id, busy, led_r, led_g, led_b);
        end
        req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_idle: cycle %0d got gnt=%b busy=%b expected 0000/0", k, gnt, busy);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] segs [4];
        segs = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        apply_reset();
        req = 4'b1011;
        step();
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < HOLD; c++) begin
                n_checks++;
                if (gnt !== segs[s]) begin
                    n_fail++;
                    $display("FAIL rr_hold: owner %0d cycle %0d got gnt=%b expected %b", s, c, gnt, segs[s]);
                end
                step();
            end
        end
        n_checks++;
        if (gnt !== segs[3] || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rr_wrap: got gnt=%b id=%0d expected %b/0", gnt, gnt_id, segs[3]);
        end
    endtask

    task automatic test_release();
        apply_reset();
        req = 4'b1010;
        step();
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (gnt !== 4'b0010) begin
                n_fail++;
                $display("FAIL release_own: cycle %0d got gnt=%b expected 0010", c, gnt);
            end
            if (c < 2) step();
        end
        req = 4'b1000;
        step();
        n_checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL release_pass: got gnt=%b id=%0d expected 1000/3", gnt, gnt_id);
        end
        req = 4'b1010;
        for (int c = 1; c < HOLD; c++) begin
            step();
            n_checks++;
            if (gnt !== 4'b1000) begin
                n_fail++;
                $display("FAIL release_rehold: cycle %0d got gnt=%b expected 1000", c, gnt);
            end
        end
        step();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL release_preempt: got gnt=%b expected 0010", gnt);
        end
    endtask

    task automatic test_color_change();
        int cr;
        int cg;
        int cb;
        apply_reset();
        color[0 +: CW] = 12'h222;
        req = 4'b0001;
        step();
        for (int k = 0; k < PERIOD && m_cnt != 0; k++) step();
        cr = 0;
        for (int k = 0; k < PERIOD; k++) begin
            step();
            cr += int'(led_r);
        end
        n_checks++;
        if (cr != 2) begin
            n_fail++;
            $display("FAIL color_initial: got r=%0d expected 2", cr);
        end
        repeat (5) step();
        color[0 +: CW] = 12'hCCC;
        for (int k = 5; k < PERIOD; k++) begin
            step();
            n_checks++;
            if ({led_r, led_g, led_b} !== 3'b000) begin
                n_fail++;
                $display("FAIL color_midperiod: slot %0d got leds=%b%b%b expected 000", k, led_r, led_g, led_b);
            end
        end
        cr = 0; cg = 0; cb = 0;
        for (int k = 0; k < PERIOD; k++) begin
            step();
            cr += int'(led_r);
            cg += int'(led_g);
            cb += int'(led_b);
        end
        n_checks++;
        if (cr != 12 || cg != 12 || cb != 12) begin
            n_fail++;
            $display("FAIL color_new: got r=%0d g=%0d b=%0d expected 12/12/12", cr, cg, cb);
        end
    endtask

    task automatic test_all_drop();
        repeat (3) step();
        req = '0;
        step();
        n_checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL drop_idle: got busy=%b gnt=%b expected 0/0000", busy, gnt);
        end
        for (int k = 0; k < PERIOD && m_cnt != 0; k++) step();
        for (int k = 0; k < PERIOD; k++) begin
            step();
            n_checks++;
            if ({led_r, led_g, led_b} !== 3'b000) begin
                n_fail++;
                $display("FAIL drop_dark: slot %0d got leds=%b%b%b expected 000", k, led_r, led_g, led_b);
            end
        end
    endtask

    task automatic test_random();
        int slot;
        apply_reset();
        color = {$urandom(), $urandom()};
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
            if ($urandom_range(0, 15) == 0) begin
                slot = $urandom_range(0, N_REQ - 1);
                color[slot*CW +: CW] = CW'($urandom());
            end
            step();
            n_checks++;
            if (gnt !== exp_gnt() || busy !== m_busy || (m_busy && gnt_id !== 2'(m_owner))) begin
                n_fail++;
                $display("FAIL random_arb: cycle %0d req=%b got gnt=%b id=%0d busy=%b expected gnt=%b id=%0d busy=%b",
                         cyc, req, gnt, gnt_id, busy, exp_gnt(), m_owner, m_busy);
            end
            n_checks++;
            if ({led_r, led_g, led_b} !== exp_led()) begin
                n_fail++;
                $display("FAIL random_led: cycle %0d got leds=%b%b%b expected %b",
                         cyc, led_r, led_g, led_b, exp_led());
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        req   = '0;
        color = '0;
        model_reset();
        #1;
        test_reset();
        test_single();
        test_reset_mid();
        test_round_robin();
        test_release();
        test_color_change();
        test_all_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
